uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_NUM_REQ_DEFAULT = 4;
  localparam int UART_DATA_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } uart_arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: the first valid requester at or after ptr (wrapping) wins.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N = UART_NUM_REQ_DEFAULT
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int            cand_ext;
  logic [IW-1:0] cand;

  // Walk from the farthest offset back to ptr so the closest valid requester is written last.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand_ext = 0;
    cand     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_ext = int'(ptr) + k;
      if (cand_ext >= N) cand_ext = cand_ext - N;
      cand = cand_ext[IW-1:0];
      if (valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into one UART transmitter.
// Define UART_ARB_LOCK_EN to let a requester hold the grant across several bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = UART_NUM_REQ_DEFAULT,
  parameter int DATA_W  = UART_DATA_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  output logic                       baud_en,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW = $clog2(NUM_REQ);

  uart_arb_state_e state, state_nxt;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      ptr_release;
  logic [NUM_REQ-1:0] pick_valid;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  pick_byte;
  logic               arb_open;
  logic               handshake;
  logic               frame_done;

`ifdef UART_ARB_LOCK_EN
  logic lock_active;

  // While locked only the owner may win; rr_ptr already points at it.
  always_comb begin
    pick_valid = req_valid;
    if (lock_active) pick_valid = req_valid & (NUM_REQ'(1) << grant_id);
  end

  assign ptr_release = lock_active ? grant_id
                     : ((grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lock_active <= 1'b0;
    else if (handshake) lock_active <= req_lock[pick_idx];
  end
`else
  assign pick_valid  = req_valid;
  assign ptr_release = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
`endif

  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid (pick_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // rst_n gates ready so nothing is offered while reset is held with requests pending.
  assign arb_open   = (state == IDLE) && !tx_busy && rst_n;
  assign req_ready  = arb_open ? pick_grant : '0;
  assign handshake  = arb_open && pick_any;
  assign frame_done = (state == WAIT_DONE) && !tx_busy;

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_idx == IW'(i)) pick_byte = req_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    baud_en   = 1'b1;
    unique case (state)
      IDLE: begin
        baud_en = 1'b0;
        if (handshake) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // A reset mid-frame drops the captured byte along with the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      if (handshake) begin
        tx_data  <= pick_byte;
        grant_id <= pick_idx;
      end
      if (frame_done) rr_ptr <= ptr_release;
    end
  end

endmodule
